// File: rtl/shift_arb24.sv
// Two-requester arbiter sharing one external 24-bit right shifter; clamps amounts to 24.
// Optional sticky generation enabled by defining SHIFT_ARB24_STICKY_EN.
module shift_arb24 #(
  parameter int AMT_W      = 8,
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [23:0]      req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [23:0]      req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  output logic [23:0]      shf_in,
  output logic [4:0]       shf_sel,
  input  logic [23:0]      shf_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [23:0]      rsp_data,
  output logic             rsp_sticky,
  output logic             rsp_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;

  state_t           state_q;
  logic             last_q;
  logic [23:0]      data_q, rdata_q;
  logic [4:0]       sel_q;
  logic             id_q, rid_q, rsp_valid_q, sticky_q;

  logic             idle, pick1, gnt0, gnt1;
  logic [AMT_W-1:0] win_amt;
  logic [23:0]      win_data;
  logic [4:0]       amt_c;
  logic             sticky_d;

  // pick1 selects requester 1 as the winner; only meaningful while idle
  always_comb begin
    idle     = (state_q == IDLE);
    if (PRIO_FIXED)
      pick1  = req1_valid & ~req0_valid;
    else
      pick1  = req1_valid & (~req0_valid | ~last_q);
    gnt0     = idle & req0_valid & ~pick1;
    gnt1     = idle & pick1;
    win_amt  = pick1 ? req1_amt  : req0_amt;
    win_data = pick1 ? req1_data : req0_data;
    amt_c    = (win_amt >= AMT_W'(24)) ? 5'd24 : win_amt[4:0];
  end

`ifdef SHIFT_ARB24_STICKY_EN
  // sel_q=24 shifts the 1 out entirely, so the subtraction wraps to all ones
  logic [23:0] mask;
  always_comb begin
    mask     = (24'd1 << sel_q) - 24'd1;
    sticky_d = |(data_q & mask);
  end
`else
  always_comb sticky_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      data_q      <= '0;
      sel_q       <= '0;
      id_q        <= 1'b0;
      rdata_q     <= '0;
      rid_q       <= 1'b0;
      sticky_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (gnt0 | gnt1) begin
          data_q  <= win_data;
          sel_q   <= amt_c;
          id_q    <= pick1;
          last_q  <= pick1;
          state_q <= SHIFT;
        end
        SHIFT: begin
          rdata_q     <= shf_out;
          sticky_q    <= sticky_d;
          rid_q       <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign shf_in     = data_q;
  assign shf_sel    = sel_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rdata_q;
  assign rsp_sticky = sticky_q;
  assign rsp_id     = rid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_shift_arb24.sv
// Bench for shift_arb24: vector table, directed corner sequences, random run vs transaction model.
module tb_shift_arb24;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1, r0, r1;
  logic [23:0] d0, d1;
  logic [7:0]  a0, a1;
  logic [23:0] shf_in, shf_out, rsp_data;
  logic [4:0]  shf_sel;
  logic        rsp_valid, rsp_ready, rsp_sticky, rsp_id, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // external shifter
  assign shf_out = shf_in >> shf_sel;

  shift_arb24 dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_data(d0), .req0_amt(a0),
    .req1_valid(v1), .req1_ready(r1), .req1_data(d1), .req1_amt(a1),
    .shf_in(shf_in), .shf_sel(shf_sel), .shf_out(shf_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_sticky(rsp_sticky), .rsp_id(rsp_id), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampv(input logic [7:0] amt);
    return (amt >= 8'd24) ? 24 : int'(amt);
  endfunction

  function automatic bit exp_sticky(input logic [23:0] d, input int ac);
    logic [31:0] m;
    bit s;
    m = (32'd1 << ac) - 32'd1;
    s = |({8'd0, d} & m);
`ifdef SHIFT_ARB24_STICKY_EN
    return s;
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {r1, r0}, 0);
    chk("rst_shf", {shf_in, shf_sel}, 0);
    chk("rst_rsp", {rsp_data, rsp_sticky, rsp_id}, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit          id;
    logic [23:0] data;
    logic [7:0]  amt;
    logic [4:0]  sel;
    logic [23:0] rdata;
    bit          sticky_on;
  } vec_t;

  typedef struct {
    bit          id;
    logic [23:0] data;
    bit          sticky;
  } exp_t;

  vec_t vt[10];
  exp_t q[$];

  initial begin
    rst = 1'b1; v0 = 0; v1 = 0; d0 = 0; d1 = 0; a0 = 0; a1 = 0; rsp_ready = 0;
    vt[0] = '{0, 24'hF00000, 8'd4,   5'd4,  24'h0F0000, 0};
    vt[1] = '{1, 24'h00000F, 8'd3,   5'd3,  24'h000001, 1};
    vt[2] = '{0, 24'h800001, 8'd200, 5'd24, 24'h000000, 1};
    vt[3] = '{0, 24'h800001, 8'd0,   5'd0,  24'h800001, 0};
    vt[4] = '{1, 24'hABCDEF, 8'd24,  5'd24, 24'h000000, 1};
    vt[5] = '{0, 24'h123456, 8'd23,  5'd23, 24'h000000, 1};
    vt[6] = '{1, 24'hFFFFFF, 8'd25,  5'd24, 24'h000000, 1};
    vt[7] = '{0, 24'h000010, 8'd4,   5'd4,  24'h000001, 0};
    vt[8] = '{1, 24'h000100, 8'd255, 5'd24, 24'h000000, 1};
    vt[9] = '{0, 24'h000001, 8'd32,  5'd24, 24'h000000, 1};

    do_reset();

    // single-request vectors: grant at N, select at N+1, response at N+2
    foreach (vt[i]) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      if (vt[i].id) begin v1 = 1; d1 = vt[i].data; a1 = vt[i].amt; end
      else          begin v0 = 1; d0 = vt[i].data; a0 = vt[i].amt; end
      #1;
      chk("vec_ready", {r1, r0}, vt[i].id ? 2'b10 : 2'b01);
      chk("vec_idle_busy", busy, 0);
      @(negedge clk);
      v0 = 0; v1 = 0;
      #1;
      chk("vec_sel", shf_sel, vt[i].sel);
      chk("vec_shf_in", shf_in, vt[i].data);
      chk("vec_shift_valid", {busy, rsp_valid}, 2'b10);
      @(negedge clk);
      #1;
      chk("vec_rsp_valid", rsp_valid, 1);
      chk("vec_rsp_data", rsp_data, vt[i].rdata);
      chk("vec_rsp_id", rsp_id, vt[i].id);
`ifdef SHIFT_ARB24_STICKY_EN
      chk("vec_sticky", rsp_sticky, vt[i].sticky_on);
`else
      chk("vec_sticky", rsp_sticky, 0);
`endif
      @(negedge clk);
      #1;
      chk("vec_done", {busy, rsp_valid}, 0);
    end

    // response held while consumer stalls; waiting requester not granted
    do_reset();
    @(negedge clk);
    v0 = 1; d0 = 24'h00FF00; a0 = 8'd8; rsp_ready = 0;
    #1; chk("hold_grant0", {r1, r0}, 2'b01);
    @(negedge clk);
    v0 = 0; v1 = 1; d1 = 24'h000100; a1 = 8'd1;
    #1; chk("hold_shift_ready", {r1, r0}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_data", rsp_data, 24'h0000FF);
      chk("hold_id", rsp_id, 0);
      chk("hold_busy", busy, 1);
      chk("hold_ready", {r1, r0}, 0);
    end
    @(negedge clk);
    rsp_ready = 1;
    #1; chk("hold_release_ready", {r1, r0, rsp_valid}, 3'b001);
    @(negedge clk);
    #1; chk("hold_next_grant", {r1, r0, rsp_valid, busy}, 4'b1000);
    @(negedge clk);
    v1 = 0;
    repeat (4) @(negedge clk);

    // both valid continuously: round-robin from reset
    do_reset();
    @(negedge clk);
    v0 = 1; d0 = 24'h000F00; a0 = 8'd8;
    v1 = 1; d1 = 24'h0F0000; a1 = 8'd16;
    rsp_ready = 1;
    begin
      int n = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
        #1;
        if (rsp_valid) begin
          chk("rr_id", rsp_id, n[0]);
          chk("rr_data", rsp_data, 24'h00000F);
          n++;
        end
        @(negedge clk);
      end
      chk("rr_count", n, 4);
    end
    v0 = 0; v1 = 0;
    repeat (4) @(negedge clk);

    // reset during SHIFT drops the operation and restores req0 tie priority
    do_reset();
    @(negedge clk);
    v0 = 1; d0 = 24'h0000F0; a0 = 8'd2; rsp_ready = 1;
    #1; chk("mrst_grant", {r1, r0}, 2'b01);
    @(negedge clk);
    v0 = 0; rst = 1;
    #1; chk("mrst_shift_busy", busy, 1);
    @(negedge clk);
    rst = 0; v0 = 1; v1 = 1; d1 = 24'h000003; a1 = 8'd1;
    #1;
    chk("mrst_after", {rsp_valid, busy}, 0);
    chk("mrst_tie", {r1, r0}, 2'b01);
    @(negedge clk);
    v0 = 0; v1 = 0;
    repeat (4) @(negedge clk);

    // random traffic against a transaction-level model
    do_reset();
    begin
      int    cyc = 0, grant_cyc = -100, outstanding = 0;
      bit    mlast = 1'b1, clr0 = 0, clr1 = 0;
      bit    eg0, eg1, w;
      exp_t  e;
      for (int it = 0; it < 3000; it++) begin
        @(negedge clk);
        cyc++;
        if (clr0) v0 = 0;
        if (clr1) v1 = 0;
        clr0 = 0; clr1 = 0;
        if (!v0 && ($urandom % 3 == 0)) begin
          v0 = 1; d0 = 24'($urandom);
          a0 = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom % 26);
        end
        if (!v1 && ($urandom % 3 == 0)) begin
          v1 = 1; d1 = 24'($urandom);
          a1 = ($urandom % 4 == 0) ? 8'($urandom) : 8'($urandom % 26);
        end
        rsp_ready = ($urandom % 2 == 0);
        #1;
        eg0 = 0; eg1 = 0; w = 0;
        if (outstanding == 0 && (v0 || v1)) begin
          w = (v0 && v1) ? ~mlast : v1;
          if (w) eg1 = 1; else eg0 = 1;
        end
        chk("rnd_grant", {r1, r0}, {eg1, eg0});
        chk("rnd_busy", busy, outstanding != 0);
        chk("rnd_rsp_valid", rsp_valid, (outstanding != 0) && (cyc - grant_cyc >= 2));
        if (rsp_valid && outstanding != 0 && q.size() > 0) begin
          chk("rnd_rsp_data", rsp_data, q[0].data);
          chk("rnd_rsp_id", rsp_id, q[0].id);
          chk("rnd_rsp_sticky", rsp_sticky, q[0].sticky);
          if (rsp_ready) begin
            void'(q.pop_front());
            outstanding = 0;
          end
        end
        if (eg0 || eg1) begin
          e.id     = w;
          e.data   = w ? (d1 >> clampv(a1)) : (d0 >> clampv(a0));
          e.sticky = w ? exp_sticky(d1, clampv(a1)) : exp_sticky(d0, clampv(a0));
          q.push_back(e);
          mlast = w;
          outstanding = 1;
          grant_cyc = cyc;
          if (w) clr1 = 1; else clr0 = 1;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_arb24.md
Name: shift_arb24

Overview:
- Controller that shares one 24-bit barrel right shifter (5-bit shift select) between two requesters, e.g. the exponent-alignment and normalize paths of the FP unit.
- Arbitrates requests with valid/ready and registers the chosen operand.
- Drives the external shifter, clamps shift amounts that exceed the mantissa width, and returns a registered result with requester ID and an optional sticky bit.

Parameters:
- AMT_W, 8, width of requester shift amount (an exponent difference).
- PRIO_FIXED, 0, 0 = round-robin arbitration; 1 = requester 0 always wins.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req0_valid  in  1  requester 0 has an operand
- req0_ready  out  1  requester 0 accepted this cycle
- req0_data  in  24  requester 0 mantissa
- req0_amt  in  AMT_W  requester 0 shift amount
- req1_valid / req1_ready / req1_data / req1_amt  same as requester 0, for requester 1
- shf_in  out  24  operand to shifter
- shf_sel  out  5  shift select to shifter
- shf_out  in  24  shifter result (combinational, same cycle)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  24  shifted mantissa
- rsp_sticky  out  1  OR of shifted-out bits
- rsp_id  out  1  requester that owns rsp_data
- busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: every output and register is 0; state = IDLE; last_grant = 1, so requester 0 wins the first tie.
- FSM has three states: IDLE, SHIFT, RESP.
- IDLE:
  - If any reqX_valid, grant one requester. reqX_ready = grant, combinational from valid and state, high for exactly one cycle.
  - On grant, capture data, clamped amount and ID; go to SHIFT.
  - No valid request: stay in IDLE. reqX_ready is 0 in every other state.
- Arbitration:
  - PRIO_FIXED=0: when both requesters are valid, grant the one that is not last_grant.
  - PRIO_FIXED=1: requester 0 always wins.
  - A single valid requester is always granted.
  - last_grant updates on every grant.
- Clamp: amt_c = (amt >= 24) ? 24 : amt[4:0]. Compare the full AMT_W bits; no truncation before the compare.
- SHIFT:
  - shf_in = captured data; shf_sel = amt_c. Both are registered and change only on capture.
  - Register rsp_data <= shf_out and compute rsp_sticky; go to RESP.
  - amt_c=24 yields rsp_data=0 from the shifter; the block does not mask it.
- RESP:
  - rsp_valid=1; rsp_data, rsp_sticky and rsp_id are held stable while rsp_ready=0.
  - On rsp_valid & rsp_ready, go to IDLE and deassert rsp_valid on the next cycle.
  - No arbitration happens in RESP; a request waiting in the same cycle is granted in the following IDLE cycle.
- Timing: acceptance at cycle N gives rsp_valid at N+2. Peak throughput is one operation per 3 cycles.
- Amount 0 passes the data through, with sticky=0.
- Reset mid-operation: any state returns to IDLE the cycle after rst. The in-flight operand and pending response are dropped (rsp_valid=0).
- A requester dropping valid while not granted loses nothing. Requesters must keep data and amt stable while valid is high and ready is low.

Optional Feature:
- Macro: SHIFT_ARB24_STICKY_EN.
- Defined: rsp_sticky = OR of captured data bits [amt_c-1:0] (mask of amt_c low bits), computed in SHIFT from the captured operand. amt_c=24 gives the OR of all 24 bits; amt_c=0 gives 0.
- Undefined: rsp_sticky is tied to 0 and no mask logic is generated.
- All other behaviour is identical with or without the macro.

Test Plan:
- req0 data=0xF00000, amt=4, rsp_ready=1 → req0_ready at N; shf_sel=4 at N+1; rsp_valid at N+2 with rsp_data=0x0F0000, rsp_id=0, sticky=0.
- req1 data=0x00000F, amt=3 → rsp_data=0x000001, rsp_id=1, sticky=1 (STICKY_EN on), sticky=0 (off).
- req0 data=0x800001, amt=200 → shf_sel=24, rsp_data=0, sticky=1. Also amt=0 → data unchanged, sticky=0.
- Both requesters continuously valid, 4 operations:
  - PRIO_FIXED=0 → rsp_id sequence 0,1,0,1.
  - PRIO_FIXED=1 → 0,0,0,0.
- rsp_ready held low 5 cycles in RESP → rsp_data/rsp_id stable, busy=1, req0_ready and req1_ready stay 0. Raise rsp_ready → IDLE next cycle, then the next grant.
- rst pulsed for 1 cycle while in SHIFT → next cycle: rsp_valid=0, busy=0, IDLE; the first grant afterwards goes to req0 on a tie.
